temp_monitor: RTL and testbench
===============================

// Module: temp_monitor
// PURPOSE
// Conversion scheduler and post-processor for the on-die temperature sensor path.
// Periodically pulses sense_clr into temp_sense to restart a conversion.
// After a fixed wait, samples the 8-bit temp code and block-averages 2**AVG_LOG2 samples.
// Raises a hysteretic over-temp alarm and tracks raw min/max. Whole block runs in the clk125 domain.
// PARAMETERS
// PERIOD     1250000  cycles from one CLR entry to the next (10 ms @125 MHz); >= CLR_LEN+CONV_WAIT+2
// CLR_LEN    16       cycles sense_clr is held high per conversion; >= 1
// CONV_WAIT  250000   cycles from sense_clr falling to sampling temp_data; >= 1
// AVG_LOG2   2        log2 of samples per average (N = 2**AVG_LOG2); 0..4
// T_HI       8'd100   over_temp set threshold (code)
// T_LO       8'd90    over_temp clear threshold (code); T_LO < T_HI
// PORTS
// clk125     in   1  system clock, 125 MHz
// clr_n      in   1  synchronous active-low reset
// en         in   1  enable periodic conversions
// peak_clr   in   1  1-cycle pulse: reinitialise temp_max/temp_min
// temp_data  in   8  temperature code from temp_sense (static between conversions)
// sense_clr  out  1  conversion restart, drives temp_sense clr
// temp_avg   out  8  last completed average
// avg_valid  out  1  1-cycle pulse when temp_avg updates
// over_temp  out  1  alarm level with hysteresis
// temp_max   out  8  maximum raw sample since reset/peak_clr
// temp_min   out  8  minimum raw sample since reset/peak_clr
// BEHAVIOUR
// Reset (clr_n=0 at an edge): state=IDLE, counters/acc/sample count=0, sense_clr=0, temp_avg=0,
//   avg_valid=0, over_temp=0, temp_max=8'h00, temp_min=8'hFF. Reset mid-operation aborts immediately.
// FSM: IDLE, CLR, WAIT, SAMPLE, HOLD.
// - IDLE: if en=1, go to CLR next cycle; period counter pc cleared to 0.
// - CLR: sense_clr=1 for exactly CLR_LEN cycles, then WAIT. pc increments every cycle from CLR entry.
// - WAIT: sense_clr=0; counts CONV_WAIT cycles, then SAMPLE.
// - SAMPLE (1 cycle): register temp_data.
//   acc += temp_data, with acc 8+AVG_LOG2 bits wide and no overflow possible.
//   cnt += 1. Update max/min. Go to HOLD.
// - HOLD: when pc == PERIOD-1, pc <= 0 and go to CLR if en=1, else IDLE. sense_clr period = PERIOD exactly.
// en is checked only in IDLE and at the HOLD exit. Deasserting en mid-conversion completes the current sample.
// Entering IDLE from HOLD because en=0 clears acc and cnt; partial average discarded. temp_avg/alarm/peaks retained.
// Average: the cycle after the SAMPLE in which cnt reaches N:
//   temp_avg <= acc >> AVG_LOG2 (truncate); avg_valid=1 for that 1 cycle; acc, cnt <= 0.
// Alarm: evaluated only on the new temp_avg in the avg_valid cycle+1.
//   over_temp <= 1 if avg >= T_HI; <= 0 if avg <= T_LO; otherwise hold.
// Peaks: a sample updates max if sample > max and min if sample < min.
//   peak_clr in the same cycle as SAMPLE: max<=sample, min<=sample. peak_clr alone: max=00, min=FF.
// Outputs are registered; no combinational path from inputs to outputs.
// TESTING (CLR_LEN=2, CONV_WAIT=10, PERIOD=20, AVG_LOG2=2, T_HI=100, T_LO=90)
// 1 Reset: clr_n=0 for 3 cycles, then 1 with en=0.
//   -> sense_clr=0, temp_avg=0, over_temp=0, max=00, min=FF; no activity.
// 2 en=1, temp_data=50.
//   -> sense_clr high 2 cycles every 20; sample 10 cycles after it falls.
//   -> after 4th sample, avg_valid 1 cycle, temp_avg=50.
// 3 Samples 100,101,102,104 -> avg 101, over_temp=1.
//   Then 4x95 -> avg 95, stays 1. Then 4x90 -> avg 90, over_temp=0.
// 4 Samples 30,200,10 -> max=200, min=10.
//   peak_clr alone -> 00/FF. peak_clr coincident with sample 77 -> max=min=77.
// 5 en=0 during WAIT after 2 samples -> that sample taken, state IDLE, no further sense_clr.
//   Re-enable -> avg_valid only after 4 fresh samples.
// 6 clr_n=0 on the 2nd sense_clr cycle -> sense_clr=0 next edge, all outputs at reset values.

Source files
------------

// File: rtl/temp_monitor_if.sv
// Temperature monitor bus: conversion control in, post-processed results out.
interface temp_monitor_if;
  logic       en;
  logic       peak_clr;
  logic [7:0] temp_data;
  logic       sense_clr;
  logic [7:0] temp_avg;
  logic       avg_valid;
  logic       over_temp;
  logic [7:0] temp_max;
  logic [7:0] temp_min;

  modport master (output en, peak_clr, temp_data,
                  input  sense_clr, temp_avg, avg_valid, over_temp, temp_max, temp_min);
  modport slave  (input  en, peak_clr, temp_data,
                  output sense_clr, temp_avg, avg_valid, over_temp, temp_max, temp_min);
endinterface

// File: rtl/temp_monitor.sv
// Conversion scheduler and post-processor for the on-die temperature sensor.
// One period counter (pc) times the whole CLR/WAIT/SAMPLE/HOLD sequence, so
// sense_clr repeats exactly every PERIOD cycles while enabled.
module temp_monitor #(
  parameter int         PERIOD    = 1250000,
  parameter int         CLR_LEN   = 16,
  parameter int         CONV_WAIT = 250000,
  parameter int         AVG_LOG2  = 2,
  parameter logic [7:0] T_HI      = 8'd100,
  parameter logic [7:0] T_LO      = 8'd90
) (
  input  logic          i_clk125,
  input  logic          i_clr_n,
  temp_monitor_if.slave bus
);
  localparam int PC_W  = $clog2(PERIOD);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [PC_W-1:0]  PC_CLR_LAST  = PC_W'(CLR_LEN - 1);
  localparam logic [PC_W-1:0]  PC_WAIT_LAST = PC_W'(CLR_LEN + CONV_WAIT - 1);
  localparam logic [PC_W-1:0]  PC_LAST      = PC_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {IDLE, CLR, WAIT, SAMPLE, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_avg, r_max, r_min;
  logic             r_avg_valid, r_over_temp;
  logic             w_sample, w_hold_exit, w_to_idle, w_avg_done;

  assign w_sample    = (r_state == SAMPLE);
  assign w_hold_exit = (r_state == HOLD) && (r_pc == PC_LAST);
  assign w_to_idle   = w_hold_exit && !bus.en;
  assign w_avg_done  = (r_cnt == CNT_FULL);

  // State register
  always_ff @(posedge i_clk125) begin
    if (!i_clr_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: phase boundaries all come from the shared period counter
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.en) w_state_nxt = CLR;
      CLR:     if (r_pc == PC_CLR_LAST) w_state_nxt = WAIT;
      WAIT:    if (r_pc == PC_WAIT_LAST) w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = HOLD;
      HOLD:    if (r_pc == PC_LAST) w_state_nxt = bus.en ? CLR : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Period counter: zero while idle and at the wrap into the next CLR
  always_ff @(posedge i_clk125) begin
    if (!i_clr_n)                        r_pc <= '0;
    else if (r_state == IDLE || w_hold_exit) r_pc <= '0;
    else                                 r_pc <= r_pc + 1'b1;
  end

  // Block average; a completed block wins over the en-drop discard
  always_ff @(posedge i_clk125) begin
    if (!i_clr_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (w_avg_done) begin
        r_avg       <= r_acc[ACC_W-1:AVG_LOG2];
        r_avg_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
      end else if (w_to_idle) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_sample) begin
        r_acc <= r_acc + ACC_W'(bus.temp_data);
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Hysteretic alarm, looks only at the freshly published average
  always_ff @(posedge i_clk125) begin
    if (!i_clr_n)                  r_over_temp <= 1'b0;
    else if (r_avg_valid) begin
      if (r_avg >= T_HI)           r_over_temp <= 1'b1;
      else if (r_avg <= T_LO)      r_over_temp <= 1'b0;
    end
  end

  // Raw peak tracking; a clear coincident with a sample seeds both with it
  always_ff @(posedge i_clk125) begin
    if (!i_clr_n) begin
      r_max <= 8'h00;
      r_min <= 8'hFF;
    end else if (bus.peak_clr && w_sample) begin
      r_max <= bus.temp_data;
      r_min <= bus.temp_data;
    end else if (bus.peak_clr) begin
      r_max <= 8'h00;
      r_min <= 8'hFF;
    end else if (w_sample) begin
      if (bus.temp_data > r_max) r_max <= bus.temp_data;
      if (bus.temp_data < r_min) r_min <= bus.temp_data;
    end
  end

  assign bus.sense_clr = (r_state == CLR);
  assign bus.temp_avg  = r_avg;
  assign bus.avg_valid = r_avg_valid;
  assign bus.over_temp = r_over_temp;
  assign bus.temp_max  = r_max;
  assign bus.temp_min  = r_min;
endmodule

// File: tb/tb_temp_monitor.sv
// Randomized bench for temp_monitor against a phase-offset reference model.
module tb_temp_monitor;
  localparam int PERIOD = 20, CLR_LEN = 2, CONV_WAIT = 10, AVG_LOG2 = 2;
  localparam int N = 1 << AVG_LOG2;
  localparam int SPH = CLR_LEN + CONV_WAIT;   // phase of the sample cycle

  logic gclk = 1'b0;
  logic clr_n;
  temp_monitor_if bus ();

  always #4 gclk = ~gclk;

  temp_monitor #(.PERIOD(PERIOD), .CLR_LEN(CLR_LEN), .CONV_WAIT(CONV_WAIT),
                 .AVG_LOG2(AVG_LOG2), .T_HI(8'd100), .T_LO(8'd90))
    dut (.i_clk125(gclk), .i_clr_n(clr_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_sclr = 0;

  // reference model: conversion phase within the period, list of pending samples
  bit m_run, m_due, m_valid, m_ot;
  int m_ph, m_avg, m_max, m_min;
  int q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit prev_valid, smp;
    int sum;
    if (!clr_n) begin
      m_run = 0; m_due = 0; m_valid = 0; m_ot = 0;
      m_ph = 0; m_avg = 0; m_max = 0; m_min = 255;
      q.delete();
      return;
    end
    prev_valid = m_valid;
    m_valid = 0;
    if (prev_valid) begin
      if (m_avg >= 100) m_ot = 1;
      else if (m_avg <= 90) m_ot = 0;
    end
    if (m_due) begin
      sum = 0;
      foreach (q[i]) sum += q[i];
      m_avg = sum / N;
      m_valid = 1;
      m_due = 0;
      q.delete();
    end
    smp = m_run && (m_ph == SPH);
    if (bus.peak_clr && smp) begin
      m_max = bus.temp_data; m_min = bus.temp_data;
    end else if (bus.peak_clr) begin
      m_max = 0; m_min = 255;
    end else if (smp) begin
      if (bus.temp_data > m_max) m_max = bus.temp_data;
      if (bus.temp_data < m_min) m_min = bus.temp_data;
    end
    if (smp) begin
      q.push_back(int'(bus.temp_data));
      if (q.size() == N) m_due = 1;
    end
    if (m_run) begin
      if (m_ph == PERIOD - 1) begin
        m_ph = 0;
        if (!bus.en) begin
          m_run = 0;
          if (!m_due) q.delete();
        end
      end else m_ph++;
    end else if (bus.en) begin
      m_run = 1; m_ph = 0;
    end
  endtask

  task automatic cyc();
    @(posedge gclk);
    model_edge();
    #1;
    chk("sense_clr", int'(bus.sense_clr), int'(m_run && m_ph < CLR_LEN));
    chk("avg_valid", int'(bus.avg_valid), int'(m_valid));
    chk("temp_avg",  int'(bus.temp_avg),  m_avg);
    chk("over_temp", int'(bus.over_temp), int'(m_ot));
    chk("temp_max",  int'(bus.temp_max),  m_max);
    chk("temp_min",  int'(bus.temp_min),  m_min);
    n_valid += int'(bus.avg_valid);
    n_sclr  += int'(bus.sense_clr);
  endtask

  task automatic conv(input int v, input bit pclr);
    bus.temp_data = 8'(v);
    bus.peak_clr  = pclr;
    cyc();
    bus.peak_clr  = 1'b0;
    repeat (PERIOD - 1) cyc();
  endtask

  task automatic wait_phase(input int p);
    int k;
    for (k = 0; k < 3 * PERIOD; k++) begin
      if (m_run && m_ph == p) break;
      cyc();
    end
    if (k == 3 * PERIOD) chk("wait_phase_timeout", 0, 1);
  endtask

  initial begin
    clr_n = 1'b0;
    bus.en = 1'b0; bus.peak_clr = 1'b0; bus.temp_data = 8'd0;
    // reset and quiet idle
    repeat (3) cyc();
    clr_n = 1'b1;
    n_sclr = 0;
    repeat (8) cyc();
    chk("idle_no_clr", n_sclr, 0);
    chk("rst_min", int'(bus.temp_min), 255);

    // steady 50
    bus.en = 1'b1;
    n_sclr = 0; n_valid = 0;
    repeat (4) conv(50, 0);
    chk("avg50", int'(bus.temp_avg), 50);
    chk("avg50_pulses", n_valid, 1);
    chk("clr_cycles", n_sclr, 4 * CLR_LEN);

    // alarm hysteresis
    conv(100, 0); conv(101, 0); conv(102, 0); conv(104, 0);
    chk("avg101", int'(bus.temp_avg), 101);
    chk("ot_set", int'(bus.over_temp), 1);
    repeat (4) conv(95, 0);
    chk("ot_hold", int'(bus.over_temp), 1);
    repeat (4) conv(90, 0);
    chk("ot_clear", int'(bus.over_temp), 0);

    // peaks
    conv(30, 0); conv(200, 0); conv(10, 0);
    chk("max200", int'(bus.temp_max), 200);
    chk("min10",  int'(bus.temp_min), 10);
    bus.peak_clr = 1'b1; cyc(); bus.peak_clr = 1'b0;
    chk("pclr_max", int'(bus.temp_max), 0);
    chk("pclr_min", int'(bus.temp_min), 255);
    bus.temp_data = 8'd77;
    wait_phase(SPH);
    bus.peak_clr = 1'b1; cyc(); bus.peak_clr = 1'b0;
    chk("pk77_max", int'(bus.temp_max), 77);
    chk("pk77_min", int'(bus.temp_min), 77);
    wait_phase(0);

    // random conversions in whole blocks
    repeat (12) conv(int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));

    // en dropped mid-conversion after two samples of a block
    conv(int'($urandom_range(0, 255)), 0);
    conv(int'($urandom_range(0, 255)), 0);
    wait_phase(5);
    bus.en = 1'b0;
    repeat (PERIOD) cyc();
    n_sclr = 0;
    repeat (2 * PERIOD) cyc();
    chk("dis_no_clr", n_sclr, 0);
    bus.en = 1'b1;
    n_valid = 0;
    repeat (3) conv(int'($urandom_range(0, 255)), 0);
    chk("fresh_no_avg", n_valid, 0);
    conv(int'($urandom_range(0, 255)), 0);
    chk("fresh_avg", n_valid, 1);

    // reset on the second sense_clr cycle
    wait_phase(1);
    clr_n = 1'b0;
    cyc();
    chk("rst_sclr", int'(bus.sense_clr), 0);
    chk("rst_avg",  int'(bus.temp_avg), 0);
    chk("rst_max",  int'(bus.temp_max), 0);
    clr_n = 1'b1; bus.en = 1'b0;
    repeat (5) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
